router_pkt_tx: RTL and testbench

- Packet source for the 1x3 router input port. It drives packet_valid and the data byte, and honours busy.
- Accepts a destination/length command, then buffers the full payload internally so the packet goes out with no gaps.
- Frame on the wire: header {len[5:0], addr[1:0]}, then len payload bytes, then one parity byte (XOR of header and all payload bytes).
- Samples the router's err after each packet and keeps a saturating error count. Used in the system bench and as the upstream source in the SoC.

---
 rtl/router_pkg.sv | 24 ++
 rtl/router_tx_buf.sv | 27 ++
 rtl/router_pkt_tx.sv | 183 ++++++++++++++++++
 tb/tb_router_pkt_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and helpers for the router packet source.
// Holds the FSM encoding, address/length limits and header packing.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        HDR,
        PAY,
        PAR,
        GAP
    } state_e;

    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int         MAX_LEN      = 63;

    function automatic logic [7:0] hdr_pack(
        input logic [5:0] len,
        input logic [1:0] addr
    );
        return {len, addr};
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; every byte is written before use.
module router_tx_buf
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] raddr,
    output logic [7:0] rdata
);

    localparam int DEPTH = MAX_LEN + 1;

    logic [7:0] mem [DEPTH];

    // Capture one payload byte per accepted beat
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a full payload, then sends
// header, payload and parity gap-free, and counts packets that drew err.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_addr,
    input  logic [5:0]       cmd_len,
    output logic             cmd_rej,
    input  logic             pl_valid,
    output logic             pl_ready,
    input  logic [7:0]       pl_data,
    input  logic             busy,
    input  logic             err,
    output logic             packet_valid,
    output logic [7:0]       pkt_data,
    output logic             tx_active,
    output logic             pkt_done,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [1:0]       addr_q, addr_d;
    logic [5:0]       len_q, len_d;
    logic [5:0]       wr_ptr_q, wr_ptr_d;
    logic [5:0]       rd_ptr_q, rd_ptr_d;
    logic [7:0]       par_q, par_d;
    logic [7:0]       data_q, data_d;
    logic             pv_q, pv_d;
    logic             rej_q, rej_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             eseen_q, eseen_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic             buf_we;
    logic [7:0]       buf_rdata;
    logic             done;

    router_tx_buf u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_ptr_q),
        .wdata (pl_data),
        .raddr (rd_ptr_q),
        .rdata (buf_rdata)
    );

    // Next-state, datapath loads and pulse generation
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        par_d    = par_q;
        data_d   = data_q;
        pv_d     = pv_q;
        rej_d    = 1'b0;
        gap_d    = gap_q;
        eseen_d  = eseen_q;
        ecnt_d   = ecnt_q;
        buf_we   = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_addr == ADDR_INVALID || cmd_len == 6'd0) begin
                        rej_d = 1'b1;
                    end else begin
                        addr_d   = cmd_addr;
                        len_d    = cmd_len;
                        wr_ptr_d = 6'd0;
                        rd_ptr_d = 6'd0;
                        par_d    = hdr_pack(cmd_len, cmd_addr);
                        state_d  = FILL;
                    end
                end
            end
            FILL: begin
                if (pl_valid) begin
                    buf_we   = 1'b1;
                    par_d    = par_q ^ pl_data;
                    wr_ptr_d = wr_ptr_q + 6'd1;
                    if (wr_ptr_q == len_q - 6'd1) begin
                        data_d  = hdr_pack(len_q, addr_q);
                        pv_d    = 1'b1;
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                if (!busy) begin
                    data_d   = buf_rdata;
                    rd_ptr_d = rd_ptr_q + 6'd1;
                    state_d  = PAY;
                end
            end
            PAY: begin
                if (!busy) begin
                    // rd_ptr is one ahead of the byte on the wire
                    if (rd_ptr_q == len_q) begin
                        data_d  = par_q;
                        pv_d    = 1'b0;
                        state_d = PAR;
                    end else begin
                        data_d   = buf_rdata;
                        rd_ptr_d = rd_ptr_q + 6'd1;
                    end
                end
            end
            PAR: begin
                if (!busy) begin
                    data_d  = 8'd0;
                    gap_d   = '0;
                    eseen_d = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                eseen_d = eseen_q | err;
                if (gap_q == GAP_LAST) begin
                    done = 1'b1;
                    if ((eseen_q | err) && ecnt_q != '1) begin
                        ecnt_d = ecnt_q + 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 2'd0;
            len_q    <= 6'd0;
            wr_ptr_q <= 6'd0;
            rd_ptr_q <= 6'd0;
            par_q    <= 8'd0;
            data_q   <= 8'd0;
            pv_q     <= 1'b0;
            rej_q    <= 1'b0;
            gap_q    <= '0;
            eseen_q  <= 1'b0;
            ecnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            par_q    <= par_d;
            data_q   <= data_d;
            pv_q     <= pv_d;
            rej_q    <= rej_d;
            gap_q    <= gap_d;
            eseen_q  <= eseen_d;
            ecnt_q   <= ecnt_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign pl_ready     = (state_q == FILL);
    assign tx_active    = (state_q != IDLE);
    assign cmd_rej      = rej_q;
    assign packet_valid = pv_q;
    assign pkt_data     = data_q;
    assign pkt_done     = done;
    assign err_cnt      = ecnt_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: table of packets plus
// hand-written stall, reject, max-length, saturation and reset cases.
module tb_router_pkt_tx;

    localparam int GAPC = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_addr;
    logic [5:0] cmd_len;
    logic       cmd_rej;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] pl_data;
    logic       busy;
    logic       err;
    logic       packet_valid;
    logic [7:0] pkt_data;
    logic       tx_active;
    logic       pkt_done;
    logic [7:0] err_cnt;

    router_pkt_tx #(.GAP_CYCLES(GAPC), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_rej      (cmd_rej),
        .pl_valid     (pl_valid),
        .pl_ready     (pl_ready),
        .pl_data      (pl_data),
        .busy         (busy),
        .err          (err),
        .packet_valid (packet_valid),
        .pkt_data     (pkt_data),
        .tx_active    (tx_active),
        .pkt_done     (pkt_done),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  a;
        logic [5:0]  l;
        logic [31:0] p;
        logic        e;
        logic [7:0]  hdr;
        logic [7:0]  par;
    } vec_t;

    vec_t       vecs [4];
    logic [7:0] pl [64];
    int         checks   = 0;
    int         failures = 0;
    int         exp_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Starts and ends at a negedge. bk: wire slot to stall on,
    // rk: wire slot at which reset is asserted (-1 = none).
    task automatic send(input logic [1:0] a, input logic [5:0] l,
                        input logic e, input int bk, input int bc,
                        input logic [7:0] hdr, input logic [7:0] par,
                        input int rk);
        logic [7:0] exp;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        chk("cmd_ready", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        chk("pl_ready", pl_ready, 1);
        for (int i = 0; i < int'(l); i++) begin
            pl_valid = 1'b1;
            pl_data  = pl[i];
            step();
        end
        pl_valid = 1'b0;
        for (int k = 0; k <= int'(l) + 1; k++) begin
            if (k == 0) exp = hdr;
            else if (k <= int'(l)) exp = pl[k-1];
            else exp = par;
            chk("pkt_data", pkt_data, exp);
            chk("packet_valid", packet_valid, (k <= int'(l)) ? 1 : 0);
            if (k == rk) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                exp_cnt = 0;
                chk("rst_tx_active", tx_active, 0);
                chk("rst_packet_valid", packet_valid, 0);
                chk("rst_pkt_data", pkt_data, 0);
                chk("rst_err_cnt", err_cnt, 0);
                chk("rst_cmd_ready", cmd_ready, 1);
                return;
            end
            if (k == bk) begin
                busy = 1'b1;
                repeat (bc) begin
                    step();
                    chk("hold_data", pkt_data, exp);
                    chk("hold_valid", packet_valid, 1);
                end
                busy = 1'b0;
            end
            step();
        end
        err = e;
        for (int g = 0; g < GAPC; g++) begin
            chk("pkt_done", pkt_done, (g == GAPC - 1) ? 1 : 0);
            chk("gap_valid", packet_valid, 0);
            step();
        end
        err = 1'b0;
        if (e && exp_cnt != 255) exp_cnt++;
        chk("err_cnt", err_cnt, exp_cnt);
        chk("tx_idle", tx_active, 0);
    endtask

    task automatic reject(input logic [1:0] a, input logic [5:0] l);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        step();
        cmd_valid = 1'b0;
        chk("cmd_rej", cmd_rej, 1);
        chk("rej_tx_active", tx_active, 0);
        chk("rej_pl_ready", pl_ready, 0);
        step();
        chk("rej_pulse_end", cmd_rej, 0);
        chk("rej_still_idle", tx_active, 0);
    endtask

    initial begin
        vecs[0] = '{a: 2'd1, l: 6'd3, p: 32'h0033_2211, e: 1'b0,
                    hdr: 8'h0D, par: 8'h0D};
        vecs[1] = '{a: 2'd0, l: 6'd1, p: 32'h0000_00A5, e: 1'b0,
                    hdr: 8'h04, par: 8'hA1};
        vecs[2] = '{a: 2'd2, l: 6'd2, p: 32'h0000_0FFF, e: 1'b0,
                    hdr: 8'h0A, par: 8'hFA};
        vecs[3] = '{a: 2'd1, l: 6'd4, p: 32'h0804_0201, e: 1'b1,
                    hdr: 8'h11, par: 8'h1E};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = 2'd0;
        cmd_len   = 6'd0;
        pl_valid  = 1'b0;
        pl_data   = 8'd0;
        busy      = 1'b0;
        err       = 1'b0;
        @(negedge clk);
        step();
        chk("reset_packet_valid", packet_valid, 0);
        chk("reset_pkt_data", pkt_data, 0);
        chk("reset_cmd_rej", cmd_rej, 0);
        chk("reset_pkt_done", pkt_done, 0);
        chk("reset_err_cnt", err_cnt, 0);
        chk("reset_tx_active", tx_active, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 4; i++) pl[i] = vecs[v].p[8*i +: 8];
            send(vecs[v].a, vecs[v].l, vecs[v].e, -1, 0,
                 vecs[v].hdr, vecs[v].par, -1);
        end
        chk("cnt_after_table", err_cnt, 1);

        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send(2'd1, 6'd3, 1'b0, 2, 4, 8'h0D, 8'h0D, -1);

        reject(2'd3, 6'd5);
        reject(2'd0, 6'd0);

        for (int i = 0; i < 63; i++) pl[i] = 8'(i);
        send(2'd2, 6'd63, 1'b0, -1, 0, 8'hFE, 8'hC1, -1);

        pl[0] = 8'hA5;
        for (int n = 0; n < 256; n++) begin
            send(2'd0, 6'd1, 1'b1, -1, 0, 8'h04, 8'hA1, -1);
        end
        chk("err_cnt_saturated", err_cnt, 8'hFF);

        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send(2'd1, 6'd3, 1'b0, -1, 0, 8'h0D, 8'h0D, 3);
        send(2'd1, 6'd3, 1'b0, -1, 0, 8'h0D, 8'h0D, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
